// File: rtl/bounce_box_control.sv
// Bouncing-box sequencer: walks a square box through draw, frame wait, erase and move,
// emitting one VGA pixel write per clock while drawing or erasing.
module bounce_box_control #(
  parameter int unsigned FRAME_DIV       = 833334,
  parameter int unsigned FRAMES_PER_MOVE = 15,
  parameter int unsigned X_MAX           = 159,
  parameter int unsigned Y_MAX           = 119,
  parameter int unsigned BOX_LOG2        = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic [2:0] color_in,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_color,
  output logic       plot,
  output logic       moved
);

  localparam int unsigned PixW    = 2 * BOX_LOG2;
  localparam int unsigned DelayW  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned FramesW = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;

  // Largest top-left coordinate that keeps the whole box on screen.
  localparam logic [7:0] XLim = 8'(X_MAX + 1 - (1 << BOX_LOG2));
  localparam logic [6:0] YLim = 7'(Y_MAX + 1 - (1 << BOX_LOG2));

  localparam logic [DelayW-1:0]  DelayLast  = DelayW'(FRAME_DIV - 1);
  localparam logic [FramesW-1:0] FramesLast = FramesW'(FRAMES_PER_MOVE - 1);

  typedef enum logic [2:0] {StIdle, StDraw, StWait, StErase, StMove} state_e;

  state_e              state_q, state_d;
  logic [7:0]          x_q, x_d;
  logic [6:0]          y_q, y_d;
  logic                dx_q, dx_d;
  logic                dy_q, dy_d;
  logic [PixW-1:0]     pix_q, pix_d;
  logic [DelayW-1:0]   delay_q, delay_d;
  logic [FramesW-1:0]  frames_q, frames_d;
  logic [2:0]          col_q, col_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      x_q      <= 8'd0;
      y_q      <= 7'd60;
      dx_q     <= 1'b1;
      dy_q     <= 1'b0;
      pix_q    <= '0;
      delay_q  <= '0;
      frames_q <= '0;
      col_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      pix_q    <= pix_d;
      delay_q  <= delay_d;
      frames_q <= frames_d;
      col_q    <= col_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    pix_d    = pix_q;
    delay_d  = delay_q;
    frames_d = frames_q;
    col_d    = col_q;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          col_d   = color_in;
          pix_d   = '0;
          state_d = StDraw;
        end
      end
      StDraw: begin
        pix_d = pix_q + 1'b1;
        if (&pix_q) begin
          pix_d    = '0;
          delay_d  = '0;
          frames_d = '0;
          state_d  = StWait;
        end
      end
      StWait: begin
        // Dropping go freezes both counters, stretching the wait.
        if (go) begin
          if (delay_q == DelayLast) begin
            delay_d  = '0;
            frames_d = frames_q + 1'b1;
            if (frames_q == FramesLast) state_d = StErase;
          end else begin
            delay_d = delay_q + 1'b1;
          end
        end
      end
      StErase: begin
        pix_d = pix_q + 1'b1;
        if (&pix_q) begin
          pix_d   = '0;
          state_d = StMove;
        end
      end
      StMove: begin
        if (dx_q && x_q == XLim) begin
          dx_d = 1'b0;
          x_d  = XLim - 8'd1;
        end else if (!dx_q && x_q == 8'd0) begin
          dx_d = 1'b1;
          x_d  = 8'd1;
        end else begin
          x_d = dx_q ? x_q + 8'd1 : x_q - 8'd1;
        end

        if (dy_q && y_q == YLim) begin
          dy_d = 1'b0;
          y_d  = YLim - 7'd1;
        end else if (!dy_q && y_q == 7'd0) begin
          dy_d = 1'b1;
          y_d  = 7'd1;
        end else begin
          y_d = dy_q ? y_q + 7'd1 : y_q - 7'd1;
        end

        col_d   = color_in;
        state_d = StDraw;
      end
      default: state_d = StIdle;
    endcase
  end

  // Low pix bits select the column, high bits the row: raster order, column fastest.
  assign vga_x     = x_q + 8'(pix_q[BOX_LOG2-1:0]);
  assign vga_y     = y_q + 7'(pix_q[PixW-1:BOX_LOG2]);
  assign plot      = (state_q == StDraw) || (state_q == StErase);
  assign vga_color = (state_q == StDraw) ? col_q : 3'd0;
  assign moved     = (state_q == StMove);

endmodule
